// File: rtl/calc_pkg.sv
// Shared Q16.16 fixed-point helpers and the backprop FSM state type.
package calc_pkg;

  localparam int          Q_W    = 32;
  localparam int          Q_FRAC = 16;
  localparam logic [31:0] Q_ONE  = 32'h0001_0000;
  localparam logic [31:0] Q_MAX  = 32'h7FFF_FFFF;
  localparam logic [31:0] Q_MIN  = 32'h8000_0000;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Keeps the sign of the full product, then the 31 bits just above the fraction.
  function automatic logic [Q_W-1:0] q_mul(input logic [Q_W-1:0] a, input logic [Q_W-1:0] b);
    logic signed [2*Q_W-1:0] ae;
    logic signed [2*Q_W-1:0] be;
    logic signed [2*Q_W-1:0] p;
    logic [Q_W-1:0]          r;
    ae = $signed({{Q_W{a[Q_W-1]}}, a});
    be = $signed({{Q_W{b[Q_W-1]}}, b});
    p  = ae * be;
    r  = Q_W'(p >>> Q_FRAC);
    r[Q_W-1] = p[2*Q_W-1];
    return r;
  endfunction

  function automatic logic [Q_W-1:0] q_sub_sat(input logic [Q_W-1:0] a, input logic [Q_W-1:0] b);
    logic [Q_W-1:0] diff;
    diff = a - b;
    if ((a[Q_W-1] != b[Q_W-1]) && (diff[Q_W-1] != a[Q_W-1]))
      return a[Q_W-1] ? Q_MIN : Q_MAX;
    return diff;
  endfunction

endpackage

// File: rtl/neuron_backprop_if.sv
// Gradient-in / input-gradient-out stream bundle for the neuron backward pass.
interface neuron_backprop_if #(
  parameter int IDX_W = 2
);
  logic             g_valid;
  logic             g_ready;
  logic [31:0]      g_data;
  logic             gx_valid;
  logic             gx_ready;
  logic [31:0]      gx_data;
  logic [IDX_W-1:0] gx_idx;
  logic             gx_last;

  modport master (
    output g_valid, g_data, gx_ready,
    input  g_ready, gx_valid, gx_data, gx_idx, gx_last
  );

  modport slave (
    input  g_valid, g_data, gx_ready,
    output g_ready, gx_valid, gx_data, gx_idx, gx_last
  );
endinterface

// File: rtl/bp_weight_file.sv
// N_IN x 32 weight register file: one write port, one update port, two combinational reads.
module bp_weight_file #(
  parameter int N_IN  = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [31:0]      wr_data_i,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic [31:0]      upd_data_i,
  input  logic [IDX_W-1:0] rd_a_idx_i,
  output logic [31:0]      rd_a_data_o,
  input  logic [IDX_W-1:0] rd_b_idx_i,
  output logic [31:0]      rd_b_data_o
);
  logic [31:0] w_q [N_IN];

  // Write and update enables are never both high: one is IDLE-only, the other EMIT-only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_IN; k++) w_q[k] <= '0;
    end else if (wr_en_i) begin
      w_q[wr_idx_i] <= wr_data_i;
    end else if (upd_en_i) begin
      w_q[upd_idx_i] <= upd_data_i;
    end
  end

  assign rd_a_data_o = w_q[rd_a_idx_i];
  assign rd_b_data_o = w_q[rd_b_idx_i];
endmodule

// File: rtl/neuron_backprop.sv
// Backward pass of one Q16.16 ReLU neuron: gates the gradient, streams gx[i], updates w[i].
// Build option WEIGHT_SAT_EN: weight subtraction saturates instead of wrapping.
//
// state | meaning
// IDLE  | accepts weight writes, forward context and the next gradient
// EMIT  | presents gx[idx_q]; each handshake retires that weight's update
module neuron_backprop
  import calc_pkg::*;
#(
  parameter int          N_IN  = 4,
  parameter int          IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1,
  parameter logic [31:0] LR    = 32'h0000_0100
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                w_we,
  input  logic [IDX_W-1:0]    w_idx,
  input  logic [Q_W-1:0]      w_wdata,
  output logic [Q_W-1:0]      w_rdata,
  input  logic                fwd_valid,
  input  logic [Q_W*N_IN-1:0] fwd_x,
  input  logic                fwd_d,
  neuron_backprop_if.slave    bp,
  output logic                busy
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [Q_W-1:0]   delta_q, delta_d;
  logic [Q_W-1:0]   x_q [N_IN];
  logic [Q_W-1:0]   x_d [N_IN];
  logic             d_q, d_d;
  logic             wr_en, upd_en;
  logic [Q_W-1:0]   w_cur, grad_w, step, w_new;

  assign wr_en = w_we && (state_q == IDLE);

  bp_weight_file #(.N_IN(N_IN), .IDX_W(IDX_W)) u_wfile (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en_i     (wr_en),
    .wr_idx_i    (w_idx),
    .wr_data_i   (w_wdata),
    .upd_en_i    (upd_en),
    .upd_idx_i   (idx_q),
    .upd_data_i  (w_new),
    .rd_a_idx_i  (idx_q),
    .rd_a_data_o (w_cur),
    .rd_b_idx_i  (w_idx),
    .rd_b_data_o (w_rdata)
  );

  assign grad_w     = q_mul(delta_q, x_q[idx_q]);
  assign step       = q_mul(LR, grad_w);
  assign bp.gx_data = q_mul(delta_q, w_cur);
  assign bp.gx_idx  = idx_q;

`ifdef WEIGHT_SAT_EN
  assign w_new = q_sub_sat(w_cur, step);
`else
  assign w_new = w_cur - step;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    delta_d     = delta_q;
    x_d         = x_q;
    d_d         = d_q;
    upd_en      = 1'b0;
    bp.g_ready  = (state_q == IDLE);
    bp.gx_valid = (state_q == EMIT);
    bp.gx_last  = (state_q == EMIT) && (idx_q == LAST_IDX);
    busy        = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (fwd_valid) begin
          for (int k = 0; k < N_IN; k++) x_d[k] = fwd_x[Q_W*k +: Q_W];
          d_d = fwd_d;
        end
        // Gating uses d_q, so a same-cycle forward capture only affects the next pass.
        if (bp.g_valid) begin
          delta_d = d_q ? bp.g_data : '0;
          idx_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (bp.gx_ready) begin
          upd_en = 1'b1;
          if (idx_q == LAST_IDX) state_d = IDLE;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      delta_q <= '0;
      d_q     <= 1'b0;
      for (int k = 0; k < N_IN; k++) x_q[k] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      delta_q <= delta_d;
      d_q     <= d_d;
      for (int k = 0; k < N_IN; k++) x_q[k] <= x_d[k];
    end
  end
endmodule

// File: tb/tb_neuron_backprop.sv
// Scoreboard bench for neuron_backprop: directed passes, expected gx queued, monitor compares.
module tb_neuron_backprop;
  localparam int          N_IN  = 4;
  localparam int          IDX_W = 2;
  localparam logic [31:0] LR    = 32'h0000_0100;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              w_we = 1'b0;
  logic [IDX_W-1:0]  w_idx = '0;
  logic [31:0]       w_wdata = '0;
  logic [31:0]       w_rdata;
  logic              fwd_valid = 1'b0;
  logic [32*N_IN-1:0] fwd_x = '0;
  logic              fwd_d = 1'b0;
  logic              busy;

  typedef struct {
    logic [31:0]      data;
    logic [IDX_W-1:0] idx;
    logic             last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  neuron_backprop_if #(.IDX_W(IDX_W)) bp_if ();

  neuron_backprop #(.N_IN(N_IN), .IDX_W(IDX_W), .LR(LR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .w_we      (w_we),
    .w_idx     (w_idx),
    .w_wdata   (w_wdata),
    .w_rdata   (w_rdata),
    .fwd_valid (fwd_valid),
    .fwd_x     (fwd_x),
    .fwd_d     (fwd_d),
    .bp        (bp_if.slave),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every gx handshake must match the head of the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bp_if.gx_valid && bp_if.gx_ready) begin
        check("gx_queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("gx_data", bp_if.gx_data, e.data);
          check("gx_idx", 32'(bp_if.gx_idx), 32'(e.idx));
          check("gx_last", 32'(bp_if.gx_last), 32'(e.last));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input int idx, input logic [31:0] data);
    w_we    = 1'b1;
    w_idx   = IDX_W'(idx);
    w_wdata = data;
    tick();
    w_we    = 1'b0;
  endtask

  task automatic write_all_w(input logic [31:0] a, b, c, d);
    write_w(0, a); write_w(1, b); write_w(2, c); write_w(3, d);
  endtask

  task automatic load_fwd(input logic [31:0] x0, x1, x2, x3, input logic d);
    fwd_valid = 1'b1;
    fwd_x     = {x3, x2, x1, x0};
    fwd_d     = d;
    tick();
    fwd_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] a, b, c, d);
    logic [31:0] v [4];
    exp_t e;
    v = '{a, b, c, d};
    for (int i = 0; i < N_IN; i++) begin
      e.data = v[i];
      e.idx  = IDX_W'(i);
      e.last = (i == N_IN - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic start_g(input logic [31:0] g);
    bp_if.g_valid = 1'b1;
    bp_if.g_data  = g;
    tick();
    bp_if.g_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int exp_cycles);
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check(name, 32'(n), 32'(exp_cycles));
    check({name, "_g_ready"}, 32'(bp_if.g_ready), 32'd1);
  endtask

  task automatic check_all_w(input string name, input logic [31:0] a, b, c, d);
    logic [31:0] v [4];
    v = '{a, b, c, d};
    for (int i = 0; i < N_IN; i++) begin
      w_idx = IDX_W'(i);
      #1;
      check($sformatf("%s_w%0d", name, i), w_rdata, v[i]);
    end
  endtask

  initial begin
    bp_if.g_valid  = 1'b0;
    bp_if.g_data   = '0;
    bp_if.gx_ready = 1'b1;

    // Reset state
    #2;
    check("rst_gx_valid", 32'(bp_if.gx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gx_last", 32'(bp_if.gx_last), 32'd0);
    check("rst_gx_data", bp_if.gx_data, 32'd0);
    check("rst_g_ready", 32'(bp_if.g_ready), 32'd1);
    check("rst_w_rdata", w_rdata, 32'd0);
    #10 rst_n = 1'b1;
    tick();

    // 1: basic pass
    write_all_w(32'h0001_0000, 32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000);
    load_fwd(32'h0001_0000, 32'h0001_0000, 32'h0002_0000, 32'h0004_0000, 1'b1);
    push_exp(32'h0001_0000, 32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000);
    start_g(32'h0001_0000);
    check("t1_first_valid", 32'(bp_if.gx_valid), 32'd1);
    check("t1_first_idx", 32'(bp_if.gx_idx), 32'd0);
    wait_idle("t1_cycles", 4);
    check_all_w("t1", 32'h0000_FF00, 32'h0001_FF00, 32'hFFFE_FE00, 32'h0000_7C00);
    tick();

    // 2: dead neuron; weight write attempted mid-pass must be ignored
    load_fwd(32'h0001_0000, 32'h0001_0000, 32'h0002_0000, 32'h0004_0000, 1'b0);
    push_exp(32'h0, 32'h0, 32'h0, 32'h0);
    start_g(32'h0005_0000);
    w_we    = 1'b1;
    w_idx   = '0;
    w_wdata = 32'hDEAD_BEEF;
    wait_idle("t2_cycles", 4);
    w_we    = 1'b0;
    check_all_w("t2", 32'h0000_FF00, 32'h0001_FF00, 32'hFFFE_FE00, 32'h0000_7C00);
    tick();

    // 3: backpressure at idx 1
    write_all_w(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000);
    load_fwd(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 1'b1);
    push_exp(32'h0002_0000, 32'h0004_0000, 32'h0006_0000, 32'h0008_0000);
    start_g(32'h0002_0000);
    tick();
    bp_if.gx_ready = 1'b0;
    w_idx = 2'd1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t3_stall_valid", 32'(bp_if.gx_valid), 32'd1);
      check("t3_stall_idx", 32'(bp_if.gx_idx), 32'd1);
      check("t3_stall_data", bp_if.gx_data, 32'h0004_0000);
      check("t3_stall_w1", w_rdata, 32'h0002_0000);
      tick();
    end
    bp_if.gx_ready = 1'b1;
    tick();
    check("t3_w1_after_hs", w_rdata, 32'h0001_FE00);
    wait_idle("t3_tail_cycles", 2);
    check_all_w("t3", 32'h0000_FE00, 32'h0001_FE00, 32'h0002_FE00, 32'h0003_FE00);
    tick();

    // 4: overflow on the weight subtraction
    write_all_w(32'h7FFF_0000, 32'h0, 32'h0, 32'h0);
    load_fwd(32'hFFFF_0000, 32'h0, 32'h0, 32'h0, 1'b1);
    push_exp(32'h0001_0000, 32'h0, 32'h0, 32'h0);
    start_g(32'h7FFF_0000);
    wait_idle("t4_cycles", 4);
`ifdef WEIGHT_SAT_EN
    check_all_w("t4", 32'h7FFF_FFFF, 32'h0, 32'h0, 32'h0);
`else
    check_all_w("t4", 32'h807E_FF00, 32'h0, 32'h0, 32'h0);
`endif
    tick();

    // 5: reset mid-EMIT at idx 2
    write_all_w(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000);
    load_fwd(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 1'b1);
    push_exp(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000);
    start_g(32'h0001_0000);
    tick();
    tick();
    check("t5_idx_before_rst", 32'(bp_if.gx_idx), 32'd2);
    check("t5_remaining_exp", 32'(exp_q.size()), 32'd2);
    rst_n = 1'b0;
    #1;
    check("t5_gx_valid", 32'(bp_if.gx_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_gx_data", bp_if.gx_data, 32'd0);
    check("t5_g_ready", 32'(bp_if.g_ready), 32'd1);
    exp_q.delete();
    check_all_w("t5", 32'h0, 32'h0, 32'h0, 32'h0);
    #2 rst_n = 1'b1;
    tick();

    // 6: forward capture and gradient accept in the same cycle
    write_all_w(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000);
    load_fwd(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 1'b1);
    push_exp(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000);
    fwd_valid     = 1'b1;
    fwd_d         = 1'b0;
    bp_if.g_valid = 1'b1;
    bp_if.g_data  = 32'h0001_0000;
    tick();
    fwd_valid     = 1'b0;
    bp_if.g_valid = 1'b0;
    wait_idle("t6a_cycles", 4);
    check_all_w("t6a", 32'h0000_FF00, 32'h0001_FF00, 32'h0002_FF00, 32'h0003_FF00);
    tick();
    push_exp(32'h0, 32'h0, 32'h0, 32'h0);
    start_g(32'h0001_0000);
    wait_idle("t6b_cycles", 4);
    check_all_w("t6b", 32'h0000_FF00, 32'h0001_FF00, 32'h0002_FF00, 32'h0003_FF00);
    tick();
    tick();

    check("final_exp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
